// File: rtl/compensation_weight_encoder.sv
// compensation_weight_encoder
//   Feeds the compensation memory from a column-major weight stream
//   (SIZE rows per column, SIZE columns). Each accepted weight produces a
//   saturated MAIN_WIDTH-bit main weight. Each outlier (a value outside the
//   main range) produces its row index as a compensation word. At most SLOTS
//   compensation words are written per column. Further outliers in the same
//   column are counted in ovf_cnt_o.
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   start_i           1-cycle pulse; begins a matrix load (ignored while loading)
//   w_in_i            signed input weight; w_in_valid_i qualifies it
//   w_in_ready_o      high while loading; a transfer is valid && ready
//   main_w_o          saturated weight; main_w_valid_o strobes once per transfer
//   cmp_weight_o      row index of an outlier; cmp_valid_o is the write strobe
//   change_col_o      moves the memory on to the next column boundary
//   load_mem_done_o   level; high once the full matrix has been consumed
//   ovf_cnt_o         saturating count of outliers dropped for lack of slots
// All outputs are registered, one cycle after the accepting edge.
module compensation_weight_encoder #(
    parameter int SIZE       = 8,
    parameter int W_WIDTH    = 8,
    parameter int MAIN_WIDTH = 5,
    parameter int SLOTS      = 3,
    parameter int IDX_WIDTH  = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [W_WIDTH-1:0]    w_in_i,
    input  logic                  w_in_valid_i,
    output logic                  w_in_ready_o,
    output logic [MAIN_WIDTH-1:0] main_w_o,
    output logic                  main_w_valid_o,
    output logic [IDX_WIDTH-1:0]  cmp_weight_o,
    output logic                  cmp_valid_o,
    output logic                  change_col_o,
    output logic                  load_mem_done_o,
    output logic [7:0]            ovf_cnt_o
);

    localparam int SLOT_W = $clog2(SLOTS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A weight fits the main range iff every bit from the sign bit down to
    // bit MAIN_WIDTH-1 agrees.
    function automatic logic is_outlier(input logic [W_WIDTH-1:0] w);
        logic [W_WIDTH-MAIN_WIDTH:0] top;
        top = w[W_WIDTH-1:MAIN_WIDTH-1];
        return !((&top) || (~|top));
    endfunction

    // Clamp to the most-positive or most-negative main value, chosen by the sign bit.
    function automatic logic [MAIN_WIDTH-1:0] sat_main(input logic [W_WIDTH-1:0] w);
        logic [MAIN_WIDTH-1:0] res;
        if (!is_outlier(w)) begin
            res = w[MAIN_WIDTH-1:0];
        end else if (w[W_WIDTH-1]) begin
            res = {1'b1, {(MAIN_WIDTH-1){1'b0}}};
        end else begin
            res = {1'b0, {(MAIN_WIDTH-1){1'b1}}};
        end
        return res;
    endfunction

    state_t                state_q, state_d;
    logic [IDX_WIDTH-1:0]  row_q, row_d;
    logic [IDX_WIDTH-1:0]  col_q, col_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [7:0]            ovf_q, ovf_d;
    logic [MAIN_WIDTH-1:0] main_w_q, main_w_d;
    logic                  main_v_q, main_v_d;
    logic [IDX_WIDTH-1:0]  cmp_w_q, cmp_w_d;
    logic                  cmp_v_q, cmp_v_d;
    logic                  chg_q, chg_d;
    logic                  done_q, done_d;

    logic                  accept_s;
    logic                  outlier_s;
    logic                  write_s;
    logic [SLOT_W-1:0]     slot_next_s;

    // Next-state logic for the FSM, the counters and all registered outputs.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        slot_d    = slot_q;
        ovf_d     = ovf_q;
        main_w_d  = main_w_q;
        cmp_w_d   = cmp_w_q;
        main_v_d  = 1'b0;
        cmp_v_d   = 1'b0;
        chg_d     = 1'b0;

        accept_s    = w_in_valid_i && (state_q == ST_LOAD);
        outlier_s   = is_outlier(w_in_i);
        write_s     = accept_s && outlier_s && (slot_q < SLOT_W'(SLOTS));
        if (write_s) begin
            slot_next_s = slot_q + SLOT_W'(1);
        end else begin
            slot_next_s = slot_q;
        end

        // A start pulse has no effect during a load; only IDLE and DONE honour it.
        done_d = (state_q == ST_DONE) && !start_i;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_LOAD;
                    row_d   = {IDX_WIDTH{1'b0}};
                    col_d   = {IDX_WIDTH{1'b0}};
                    slot_d  = {SLOT_W{1'b0}};
                    ovf_d   = 8'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    main_w_d = sat_main(w_in_i);
                    main_v_d = 1'b1;
                    if (write_s) begin
                        cmp_v_d = 1'b1;
                        cmp_w_d = row_q;
                    end else if (outlier_s && (ovf_q != 8'hFF)) begin
                        ovf_d = ovf_q + 8'd1;
                    end else begin
                        ovf_d = ovf_q;
                    end
                    if (row_q == IDX_WIDTH'(SIZE - 1)) begin
                        // A column that filled every slot leaves the memory
                        // index on the next boundary already. Jumping again
                        // would skip a column.
                        chg_d  = (slot_next_s < SLOT_W'(SLOTS));
                        row_d  = {IDX_WIDTH{1'b0}};
                        slot_d = {SLOT_W{1'b0}};
                        if (col_q == IDX_WIDTH'(SIZE - 1)) begin
                            state_d = ST_DONE;
                            col_d   = {IDX_WIDTH{1'b0}};
                        end else begin
                            col_d   = col_q + IDX_WIDTH'(1);
                        end
                    end else begin
                        row_d  = row_q + IDX_WIDTH'(1);
                        slot_d = slot_next_s;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            row_q    <= {IDX_WIDTH{1'b0}};
            col_q    <= {IDX_WIDTH{1'b0}};
            slot_q   <= {SLOT_W{1'b0}};
            ovf_q    <= 8'd0;
            main_w_q <= {MAIN_WIDTH{1'b0}};
            main_v_q <= 1'b0;
            cmp_w_q  <= {IDX_WIDTH{1'b0}};
            cmp_v_q  <= 1'b0;
            chg_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            slot_q   <= slot_d;
            ovf_q    <= ovf_d;
            main_w_q <= main_w_d;
            main_v_q <= main_v_d;
            cmp_w_q  <= cmp_w_d;
            cmp_v_q  <= cmp_v_d;
            chg_q    <= chg_d;
            done_q   <= done_d;
        end
    end

    assign w_in_ready_o    = (state_q == ST_LOAD);
    assign main_w_o        = main_w_q;
    assign main_w_valid_o  = main_v_q;
    assign cmp_weight_o    = cmp_w_q;
    assign cmp_valid_o     = cmp_v_q;
    assign change_col_o    = chg_q;
    assign load_mem_done_o = done_q;
    assign ovf_cnt_o       = ovf_q;

endmodule

// File: tb/tb_compensation_weight_encoder.sv
module tb_compensation_weight_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [7:0] w_in_i;
    logic       w_in_valid_i;
    logic       w_in_ready_o;
    logic [4:0] main_w_o;
    logic       main_w_valid_o;
    logic [2:0] cmp_weight_o;
    logic       cmp_valid_o;
    logic       change_col_o;
    logic       load_mem_done_o;
    logic [7:0] ovf_cnt_o;

    compensation_weight_encoder dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .w_in_i          (w_in_i),
        .w_in_valid_i    (w_in_valid_i),
        .w_in_ready_o    (w_in_ready_o),
        .main_w_o        (main_w_o),
        .main_w_valid_o  (main_w_valid_o),
        .cmp_weight_o    (cmp_weight_o),
        .cmp_valid_o     (cmp_valid_o),
        .change_col_o    (change_col_o),
        .load_mem_done_o (load_mem_done_o),
        .ovf_cnt_o       (ovf_cnt_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Matrix in column-major order: index = col*8 + row
    logic signed [7:0] mat [64];
    // Per-beat record: {main_w[4:0], main_valid, cmp_valid, cmp_weight[2:0] (0 if no write), change_col}
    logic [10:0] exp_beat [64];
    logic [10:0] obs_beat [64];
    int          exp_ovf;
    int          stray;
    logic        end_done0, end_ready;

    // Reference model built from the rules: clamp, the first SLOTS outliers of each
    // column are written, and a column jump happens when fewer than SLOTS were written.
    task automatic model_matrix();
        int v, o, cnt;
        logic cv, cc;
        exp_ovf = 0;
        for (int c = 0; c < 8; c++) begin
            cnt = 0;
            for (int r = 0; r < 8; r++) begin
                v = int'(mat[c*8+r]);
                o = (v > 15) ? 15 : ((v < -16) ? -16 : v);
                cv = 1'b0;
                if (v > 15 || v < -16) begin
                    cnt++;
                    if (cnt <= 3) cv = 1'b1;
                    else if (exp_ovf < 255) exp_ovf++;
                end
                cc = (r == 7) && (cnt < 3);
                exp_beat[c*8+r] = {5'(o), 1'b1, cv, (cv ? 3'(r) : 3'd0), cc};
            end
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // Streams n_beats weights with random valid gaps and records what each transfer produced.
    task automatic drive_matrix(input int n_beats, input int valid_pct, input bit mid_start);
        int   idx = 0;
        int   cyc = 0;
        logic rdy;
        stray = 0;
        while (idx < n_beats) begin
            @(negedge clk);
            w_in_valid_i = ($urandom_range(99) < valid_pct);
            w_in_i       = mat[idx];
            start_i      = mid_start && (idx == 20);
            rdy          = w_in_ready_o;
            @(posedge clk);
            #1;
            if (w_in_valid_i && rdy) begin
                obs_beat[idx] = {main_w_o, main_w_valid_o, cmp_valid_o,
                                 (cmp_valid_o ? cmp_weight_o : 3'd0), change_col_o};
                idx++;
            end else if (main_w_valid_o || cmp_valid_o || change_col_o) begin
                stray++;
            end
            cyc++;
            if (cyc > 2000) begin
                n_cmp++; n_fail++;
                $display("FAIL drive_timeout: got %0d beats, required %0d", idx, n_beats);
                break;
            end
        end
        w_in_valid_i = 1'b0;
        start_i      = 1'b0;
        end_done0    = load_mem_done_o;
        end_ready    = w_in_ready_o;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({main_w_o, main_w_valid_o, cmp_weight_o, cmp_valid_o, change_col_o,
             load_mem_done_o, ovf_cnt_o, w_in_ready_o} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {main_w_o, main_w_valid_o, cmp_weight_o,
                     cmp_valid_o, change_col_o, load_mem_done_o, ovf_cnt_o, w_in_ready_o});
        end
    endtask

    task automatic test_idle_ignore();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            w_in_valid_i = 1'b1;
            w_in_i       = 8'd100;
            @(posedge clk);
            #1;
            n_cmp++;
            if ({w_in_ready_o, main_w_valid_o, cmp_valid_o, change_col_o} !== 4'd0) begin
                n_fail++;
                $display("FAIL idle_ignore: got %b required 0000",
                         {w_in_ready_o, main_w_valid_o, cmp_valid_o, change_col_o});
            end
        end
        w_in_valid_i = 1'b0;
    endtask

    task automatic test_in_range();
        int ncc = 0;
        for (int i = 0; i < 64; i++) mat[i] = 8'($urandom_range(15));
        model_matrix();
        do_start();
        drive_matrix(64, 100, 1'b0);
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (obs_beat[i] !== exp_beat[i]) begin
                n_fail++;
                $display("FAIL in_range_beat%0d: got %h required %h", i, obs_beat[i], exp_beat[i]);
            end
            ncc += int'(obs_beat[i][0]);
        end
        n_cmp++;
        if (ncc != 8) begin
            n_fail++;
            $display("FAIL in_range_change_col_count: got %0d required 8", ncc);
        end
        n_cmp++;
        if ({end_done0, end_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL in_range_done_early: got %b required 00", {end_done0, end_ready});
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (load_mem_done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL in_range_done: got %b required 1", load_mem_done_o);
        end
    endtask

    task automatic test_col0_outliers();
        for (int i = 0; i < 64; i++) mat[i] = 8'sd1;
        mat[2] = 8'sd100;
        mat[5] = 8'sd100;
        model_matrix();
        do_start();
        drive_matrix(64, 100, 1'b0);
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (obs_beat[i] !== exp_beat[i]) begin
                n_fail++;
                $display("FAIL col0_beat%0d: got %h required %h", i, obs_beat[i], exp_beat[i]);
            end
        end
        n_cmp++;
        if ({obs_beat[2], obs_beat[5], obs_beat[7]} !== {11'b01111_1_1_010_0, 11'b01111_1_1_101_0, 11'b00001_1_0_000_1}) begin
            n_fail++;
            $display("FAIL col0_rows257: got %h %h %h", obs_beat[2], obs_beat[5], obs_beat[7]);
        end
        @(posedge clk);
    endtask

    task automatic test_full_and_overflow();
        for (int i = 0; i < 64; i++) mat[i] = 8'(int'($urandom_range(31)) - 16);
        for (int r = 0; r < 8; r++) mat[r] = 8'sd1;
        for (int r = 0; r < 3; r++) mat[8+r] = -8'sd60;
        for (int r = 0; r < 8; r++) mat[24+r] = 8'sd127;
        mat[63] = 8'sd100;
        model_matrix();
        do_start();
        drive_matrix(64, 100, 1'b0);
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (obs_beat[i] !== exp_beat[i]) begin
                n_fail++;
                $display("FAIL full_beat%0d: got %h required %h", i, obs_beat[i], exp_beat[i]);
            end
        end
        n_cmp++;
        if ({obs_beat[8][10:6], obs_beat[15][0], obs_beat[63]} !== {5'b10000, 1'b0, 11'b01111_1_1_111_1}) begin
            n_fail++;
            $display("FAIL full_special: got %h %b %h", obs_beat[8][10:6], obs_beat[15][0], obs_beat[63]);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (ovf_cnt_o !== 8'd5) begin
            n_fail++;
            $display("FAIL full_ovf_cnt: got %0d required 5", ovf_cnt_o);
        end
    endtask

    task automatic test_random_valid();
        for (int i = 0; i < 64; i++)
            mat[i] = ($urandom_range(1) != 0) ? 8'($urandom_range(255)) : 8'(int'($urandom_range(31)) - 16);
        model_matrix();
        do_start();
        drive_matrix(64, 60, 1'b1);
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (obs_beat[i] !== exp_beat[i]) begin
                n_fail++;
                $display("FAIL random_beat%0d: got %h required %h", i, obs_beat[i], exp_beat[i]);
            end
        end
        n_cmp++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL random_stray_strobes: got %0d required 0", stray);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({load_mem_done_o, ovf_cnt_o} !== {1'b1, 8'(exp_ovf)}) begin
            n_fail++;
            $display("FAIL random_done_ovf: got %b/%0d required 1/%0d", load_mem_done_o, ovf_cnt_o, exp_ovf);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            w_in_valid_i = 1'b1;
            @(posedge clk);
            #1;
            n_cmp++;
            if ({w_in_ready_o, main_w_valid_o, cmp_valid_o, change_col_o, load_mem_done_o} !== 5'b00001) begin
                n_fail++;
                $display("FAIL done_ignore: got %b required 00001",
                         {w_in_ready_o, main_w_valid_o, cmp_valid_o, change_col_o, load_mem_done_o});
            end
        end
        w_in_valid_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 64; i++) mat[i] = 8'($urandom_range(255));
        model_matrix();
        do_start();
        n_cmp++;
        if ({load_mem_done_o, ovf_cnt_o, w_in_ready_o} !== 10'b0_00000000_1) begin
            n_fail++;
            $display("FAIL b2b_restart: got %b required 0000000001", {load_mem_done_o, ovf_cnt_o, w_in_ready_o});
        end
        drive_matrix(64, 100, 1'b0);
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (obs_beat[i] !== exp_beat[i]) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got %h required %h", i, obs_beat[i], exp_beat[i]);
            end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (ovf_cnt_o !== 8'(exp_ovf)) begin
            n_fail++;
            $display("FAIL b2b_ovf: got %0d required %0d", ovf_cnt_o, exp_ovf);
        end
    endtask

    task automatic test_reset_midload();
        for (int i = 0; i < 64; i++) mat[i] = 8'sd127;
        do_start();
        drive_matrix(20, 100, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({main_w_o, main_w_valid_o, cmp_weight_o, cmp_valid_o, change_col_o,
             load_mem_done_o, ovf_cnt_o, w_in_ready_o} !== 21'd0) begin
            n_fail++;
            $display("FAIL midload_reset: got %h required 0", {main_w_o, main_w_valid_o, cmp_weight_o,
                     cmp_valid_o, change_col_o, load_mem_done_o, ovf_cnt_o, w_in_ready_o});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) mat[i] = 8'(int'($urandom_range(31)) - 16);
        mat[3]  = 8'sd50;
        mat[12] = -8'sd100;
        model_matrix();
        do_start();
        drive_matrix(64, 100, 1'b0);
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (obs_beat[i] !== exp_beat[i]) begin
                n_fail++;
                $display("FAIL after_reset_beat%0d: got %h required %h", i, obs_beat[i], exp_beat[i]);
            end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({load_mem_done_o, ovf_cnt_o} !== 9'b1_00000000) begin
            n_fail++;
            $display("FAIL after_reset_done_ovf: got %b/%0d required 1/0", load_mem_done_o, ovf_cnt_o);
        end
    endtask

    initial begin
        rst          = 1'b1;
        start_i      = 1'b0;
        w_in_i       = 8'd0;
        w_in_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_idle_ignore();
        test_in_range();
        test_col0_outliers();
        test_full_and_overflow();
        test_random_valid();
        test_back_to_back();
        test_reset_midload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
